spi_slave_gen: RTL and testbench

//  Parametrised next-generation SPI slave front end, clocked directly by the master's

---
 rtl/spi_slave_gen_if.sv | 26 ++
 rtl/spi_slave_gen.sv | 128 ++++++++++++
 tb/tb_spi_slave_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_gen_if.sv
// Bus bundle between an SPI slave front end and its master/memory side.
// The master modport drives select, serial data in and read words; the slave modport drives the rest.
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
) ();
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_req;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, tx_req, busy, frame_err
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, tx_req, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave front end clocked by the serial clock: deserialises {cmd,payload} frames,
// serves read words on miso with a tx_req handshake, optional burst, and abort detection.
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter bit BURST_EN  = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_gen_if.slave  bus
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST_RX = CW'(FW - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE, RX, WAIT_TX, TX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     rx_sr_q, rx_sr_d;
  logic [FW-1:0]     rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_req_q, tx_req_d;
  logic              frame_err_q, frame_err_d;
  logic [FW-1:0]     rx_shift;

  always_comb begin
    rx_shift    = MSB_FIRST ? {rx_sr_q[FW-2:0], bus.mosi} : {bus.mosi, rx_sr_q[FW-1:1]};
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = 1'b0;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    frame_err_d = 1'b0;
    if (bus.ss_n) begin
      // cnt counts bits already driven in TX, so LAST_TX means the word went out whole
      state_d     = IDLE;
      cnt_d       = '0;
      frame_err_d = ((state_q == RX) && (cnt_q != '0)) ||
                    ((state_q == TX) && (cnt_q != LAST_TX));
    end else begin
      case (state_q)
        IDLE: begin
          rx_sr_d = rx_shift;
          cnt_d   = CW'(1);
          state_d = RX;
        end
        RX: begin
          rx_sr_d = rx_shift;
          if (cnt_q == LAST_RX) begin
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            if (rx_shift[FW-1:FW-2] == 2'b11) begin
              tx_req_d = 1'b1;
              state_d  = WAIT_TX;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_TX: begin
          if (bus.tx_valid) begin
            miso_d  = MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
            tx_sr_d = MSB_FIRST ? {bus.tx_data[DATA_W-2:0], 1'b0}
                                : {1'b0, bus.tx_data[DATA_W-1:1]};
            cnt_d   = CW'(1);
            state_d = TX;
          end
        end
        TX: begin
          if (cnt_q == LAST_TX) begin
            cnt_d = '0;
            if (BURST_EN) begin
              tx_req_d = 1'b1;
              state_d  = WAIT_TX;
            end else begin
              state_d = RX;
            end
          end else begin
            miso_d  = MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0];
            tx_sr_d = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0}
                                : {1'b0, tx_sr_q[DATA_W-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed plus randomized bench for spi_slave_gen: one MSB-first burst instance and one
// LSB-first non-burst instance, selected by sel, checked against a frame-level model.
module tb_spi_slave_gen;
  localparam int DW = 8;
  localparam int FW = DW + 2;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_rx [2];

  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_W(DW)) ifm ();
  spi_slave_gen_if #(.DATA_W(DW)) ifl ();

  assign ifm.ss_n     = sel ? 1'b1 : ss_n;
  assign ifm.mosi     = mosi;
  assign ifm.tx_data  = tx_data;
  assign ifm.tx_valid = sel ? 1'b0 : tx_valid;
  assign ifl.ss_n     = sel ? ss_n : 1'b1;
  assign ifl.mosi     = mosi;
  assign ifl.tx_data  = tx_data;
  assign ifl.tx_valid = sel ? tx_valid : 1'b0;

  spi_slave_gen #(.DATA_W(DW), .BURST_EN(1'b1), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bus(ifm.slave));
  spi_slave_gen #(.DATA_W(DW), .BURST_EN(1'b0), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bus(ifl.slave));

  logic          o_miso, o_rx_valid, o_tx_req, o_busy, o_frame_err;
  logic [FW-1:0] o_rx_data;
  assign o_miso      = sel ? ifl.miso      : ifm.miso;
  assign o_rx_valid  = sel ? ifl.rx_valid  : ifm.rx_valid;
  assign o_tx_req    = sel ? ifl.tx_req    : ifm.tx_req;
  assign o_busy      = sel ? ifl.busy      : ifm.busy;
  assign o_frame_err = sel ? ifl.frame_err : ifm.frame_err;
  assign o_rx_data   = sel ? ifl.rx_data   : ifm.rx_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic m, input logic tv, input logic [DW-1:0] td);
    @(negedge clk);
    ss_n = s; mosi = m; tx_valid = tv; tx_data = td;
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [FW-1:0] v, input int k);
    return (sel == 1'b0) ? v[FW-1-k] : v[k];
  endfunction

  function automatic logic wbit(input logic [DW-1:0] d, input int k);
    return (sel == 1'b0) ? d[DW-1-k] : d[k];
  endfunction

  task automatic send_frame(input logic [FW-1:0] v);
    logic rd, last;
    rd = (v[FW-1:FW-2] == 2'b11);
    for (int k = 0; k < FW; k++) begin
      cyc(1'b0, fbit(v, k), 1'($urandom), DW'($urandom));
      last = (k == FW - 1);
      chk("rx_valid", o_rx_valid, last);
      chk("rx_tx_req", o_tx_req, last && rd);
      chk("rx_miso", o_miso, 0);
      chk("rx_busy", o_busy, 1);
      chk("rx_frame_err", o_frame_err, 0);
      chk("rx_data", o_rx_data, last ? v : exp_rx[sel]);
    end
    exp_rx[sel] = v;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      cyc(1'b0, 1'($urandom), 1'b0, DW'($urandom));
      chk("wait_miso", o_miso, 0);
      chk("wait_tx_req", o_tx_req, 0);
      chk("wait_busy", o_busy, 1);
    end
    cyc(1'b0, 1'($urandom), 1'b1, d);
    chk("tx_miso0", o_miso, wbit(d, 0));
    for (int k = 1; k < DW; k++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
      chk("tx_miso", o_miso, wbit(d, k));
      chk("tx_tx_req", o_tx_req, 0);
      chk("tx_rx_valid", o_rx_valid, 0);
    end
    cyc(1'b0, 1'($urandom), 1'b0, DW'($urandom));
    chk("tx_end_miso", o_miso, 0);
    chk("tx_end_req", o_tx_req, (sel == 1'b0));
    chk("tx_end_busy", o_busy, 1);
  endtask

  task automatic deselect(input logic exp_err);
    cyc(1'b1, 1'($urandom), 1'($urandom), DW'($urandom));
    chk("desel_frame_err", o_frame_err, exp_err);
    chk("desel_busy", o_busy, 0);
    chk("desel_rx_valid", o_rx_valid, 0);
    chk("desel_tx_req", o_tx_req, 0);
    chk("desel_miso", o_miso, 0);
    chk("desel_rx_data", o_rx_data, exp_rx[sel]);
    cyc(1'b1, 1'($urandom), 1'b0, DW'($urandom));
    chk("idle_frame_err", o_frame_err, 0);
  endtask

  task automatic partial_frame(input logic [FW-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, fbit(v, k), 1'b0, DW'($urandom));
      chk("part_rx_valid", o_rx_valid, 0);
    end
    deselect(1'b1);
  endtask

  task automatic tx_abort(input logic [DW-1:0] d, input int k);
    cyc(1'b0, 1'($urandom), 1'b1, d);
    chk("abort_miso0", o_miso, wbit(d, 0));
    for (int j = 1; j <= k; j++) begin
      cyc(1'b0, 1'($urandom), 1'b0, DW'($urandom));
      chk("abort_miso", o_miso, wbit(d, j));
    end
    deselect(1'b1);
  endtask

  task automatic random_run(input int iters);
    logic [FW-1:0] v;
    int nw, choice;
    for (int it = 0; it < iters; it++) begin
      v = FW'($urandom);
      send_frame(v);
      if (v[FW-1:FW-2] == 2'b11) begin
        if ($urandom_range(0, 3) == 0) begin
          tx_abort(DW'($urandom), $urandom_range(0, DW - 2));
          continue;
        end
        nw = (sel == 1'b0) ? $urandom_range(1, 3) : 1;
        for (int w = 0; w < nw; w++) send_word(DW'($urandom), $urandom_range(0, 2));
        if (sel == 1'b0) begin
          deselect(1'b0);
          continue;
        end
      end
      choice = $urandom_range(0, 2);
      if (choice == 1) deselect(1'b0);
      else if (choice == 2) partial_frame(FW'($urandom), $urandom_range(1, FW - 1));
    end
    deselect(1'b0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    exp_rx[0] = '0; exp_rx[1] = '0;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_miso", o_miso, 0);
      chk("rst_rx_data", o_rx_data, 0);
      chk("rst_rx_valid", o_rx_valid, 0);
      chk("rst_tx_req", o_tx_req, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_frame_err", o_frame_err, 0);
    end
    sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1..T4 on the MSB-first burst instance
    send_frame(10'h0A5);
    deselect(1'b0);
    send_frame(10'h300);
    send_word(8'hC3, 2);
    send_word(8'h5A, 0);
    deselect(1'b0);
    partial_frame(10'h2F1, 5);
    send_frame(10'h1B7);
    send_frame(10'h06C);
    deselect(1'b0);
    random_run(25);

    // T5 on the LSB-first non-burst instance
    sel = 1'b1;
    send_frame(10'h2C3);
    deselect(1'b0);
    send_frame(10'h3FF);
    send_word(8'h81, 1);
    send_frame(10'h155);
    deselect(1'b0);
    random_run(25);

    // T6: reset during the 4th transmitted bit
    sel = 1'b0;
    send_frame(10'h3A0);
    cyc(1'b0, 1'b0, 1'b1, 8'hF0);
    for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t6_pre_miso", o_miso, wbit(8'hF0, 3));
    @(negedge clk);
    rst = 1'b1; ss_n = 1'b1;
    #1;
    exp_rx[0] = '0; exp_rx[1] = '0;
    chk("t6_miso", o_miso, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_tx_req", o_tx_req, 0);
    chk("t6_frame_err", o_frame_err, 0);
    chk("t6_rx_data", o_rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    deselect(1'b0);
    send_frame(10'h07E);
    deselect(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
